// File: rtl/vga_pkg.sv
// Shared VGA timing and colour definitions for the scan controller and the renderers.
// Defaults describe 640x480@60 Hz driven from a 100 MHz system clock.
package vga_pkg;

    localparam int VGA_CLK_DIV  = 4;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Inclusive sync windows in counter coordinates.
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam int COLOR_W = 12;
    typedef logic [COLOR_W-1:0] color_t;

    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Divides the system clock into a one-clock pixel strobe every CLK_DIV clocks.
// The first strobe appears CLK_DIV-1 clocks after reset is released.
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic p_tick_o
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    assign p_tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (p_tick_o) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster-scan controller: pixel/line counters, active-area coordinates, blanked
// registered RGB, active-low syncs and a one-clock end-of-frame strobe.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] color_in,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_end
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       p_tick;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    color_t     rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       frame_end_q, frame_end_d;
    logic       active;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk      (clk),
        .rst      (rst),
        .p_tick_o (p_tick)
    );

    assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // Coordinates decode straight from registers so they hold steady for a whole pixel.
    assign x = active ? h_cnt_q : 10'd0;
    assign y = active ? v_cnt_q[8:0] : 9'd0;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Outputs sample the pre-advance counters, so RGB and syncs trail x/y by one pixel.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (p_tick) begin
            rgb_d = active ? color_t'(color_in) : '0;
            hs_d  = ~in_window(h_cnt_q, HS_LO, HS_HI);
            vs_d  = ~in_window(v_cnt_q, VS_LO, VS_HI);
        end
        frame_end_d = p_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign {r, g, b}  = rgb_q;
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign frame_end  = frame_end_q;

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster-scan controller for the 640x480@60 Hz display path. Generates the pixel coordinates (`x`, `y`) consumed by the background and sprite renderers (e.g. the welcome-screen background), samples the 12-bit colour they return, blanks it outside the visible area, and drives registered RGB plus negative-polarity HSYNC/VSYNC to the VGA connector. Also emits a one-clock end-of-frame strobe that game logic uses for per-frame updates.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be ≥2.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels (total 800).
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines (total 525).

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `color_in` in 12: {R[3:0],G[3:0],B[3:0]} from the renderer for the current `x`,`y`.
- `x` out 10: active-area column, 0..639; 0 outside the active area.
- `y` out 9: active-area row, 0..479; 0 outside the active area.
- `r`, `g`, `b` out 4 each: registered pixel colour to the DAC.
- `hs` out 1: horizontal sync, active low.
- `vs` out 1: vertical sync, active low.
- `frame_end` out 1: one-clock pulse on the last pixel tick of a frame.

## Operation
- Pixel divider: `div_cnt` counts 0..CLK_DIV-1, wrapping. `p_tick` = (`div_cnt` == CLK_DIV-1).
- `h_cnt` (10 b) counts 0..799, advancing on `p_tick`. `v_cnt` (10 b) advances on `p_tick` when `h_cnt` == 799 and counts 0..524. Both wrap to 0; at `h_cnt`=799 and `v_cnt`=524 both become 0 on the same tick.
- `active` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE), combinational from the registered counters.
- `x` = active ? `h_cnt` : 0; `y` = active ? `v_cnt[8:0]` : 0. Both are decoded from registers only, so they are glitch-free and stable for CLK_DIV clocks.
- On `p_tick`, in the same edge as the counter advance:
  - {`r`,`g`,`b`} <= active ? `color_in` : 12'h000.
  - `hs` <= ~(`h_cnt` in [656, 751]).
  - `vs` <= ~(`v_cnt` in [490, 491]).
- Between ticks, every output register holds its value.
- `frame_end` = `p_tick` && `h_cnt`==799 && `v_cnt`==524, registered so that it is high for exactly one clock, one clock after that tick.
- `rst` mid-frame: all state returns to reset values on the next edge, with no partial line completed.

## Timing
- Reset values: `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, `r`=`g`=`b`=0, `hs`=1, `vs`=1, `frame_end`=0. Consequently `x`=0 and `y`=0 during and after reset.
- First `p_tick` falls CLK_DIV-1 clocks after `rst` deasserts.
- Upstream contract: `color_in` must be valid within CLK_DIV-1 clocks of an `x`/`y` change. This allows up to 3 cycles of ROM/mux latency at CLK_DIV=4.
- RGB, `hs` and `vs` all lag the counters by exactly one pixel (CLK_DIV clocks), so they stay mutually aligned.
- Line period is 800×CLK_DIV = 3200 clocks. `hs` low for 96 px = 384 clocks. Frame period is 525 lines. `vs` low for 2 lines = 6400 clocks.

## Structure
- Shared package `vga_pkg`: timing localparams (H_/V_ values, H_TOTAL=800, V_TOTAL=525), sync-window bounds, and the 12-bit colour type/width constant, used by all renderers.
- One sub-module, `vga_pixel_tick`: the CLK_DIV counter producing `p_tick`, reusable by the renderers.
- Counters, decode and output registers live in the top module.

## Test plan
- Reset and ticking: hold `rst` 5 clocks, then release. Required: during reset `hs`=`vs`=1, rgb=0, `x`=`y`=0. First `p_tick` 3 clocks after release. `p_tick` period exactly 4 clocks thereafter.
- Line timing: run 2 lines. Required: `hs` falls 4 clocks after the tick where `h_cnt`=656, stays low 384 clocks, and the falling-edge-to-falling-edge period is 3200 clocks.
- Frame timing and wrap: run 1 full frame plus 1 line. Required: `vs` low for 6400 clocks; `frame_end` high for one clock per 1,680,000 clocks; `h_cnt` and `v_cnt` return to 0 together.
- Colour pass-through: drive `color_in`=12'hF0A when `x`=10 and `y`=20. Required: on the following tick `r`=4'hF, `g`=4'h0, `b`=4'hA.
- Blanking: hold `color_in`=12'hFFF constant. Required: rgb=0 for every pixel with `h_cnt`≥640 or `v_cnt`≥480; `x`=`y`=0 there; rgb=12'hFFF at `h_cnt`=639, `v_cnt`=479.
- Mid-frame reset: assert `rst` for 1 clock at `h_cnt`=300, `v_cnt`=200. Required: the next edge gives all reset values, and timing restarts from (0,0) exactly as after power-up.
